cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/step controller for the single-cycle DataPath on the board top level. Turns the run
//   switch and step button into a clock-enable for the datapath: free-run, halt, or exactly
//   one instruction per button press. Drives the 5-bit register-view index for the display
//   path and counts the instructions it has executed.
// PARAMETERS
//   DB_CYCLES    250000    consecutive stable cycles before a debounced input changes level
//   SCAN_CYCLES  50000000  cycles per view step in auto-scan (AUTO_SCAN_EN builds only)
//   VIEW_W       5         width of view_sel and view
//   CNT_W        16        width of instr_count
// PORTS
//   clk          in   1       system clock, the single clock domain
//   rst          in   1       asynchronous, active-high reset
//   run_sw       in   1       raw run switch (async); 1 = free-run
//   step_btn     in   1       raw step push-button (async, bouncy)
//   view_sel     in   VIEW_W  manual register-view select from switches
//   auto_scan    in   1       1 = auto-cycle view while halted (used only with AUTO_SCAN_EN)
//   cpu_ce       out  1       datapath clock-enable; the datapath advances one instruction per high cycle
//   halted       out  1       1 when the datapath is not free-running
//   view         out  VIEW_W  register index presented to the datapath view input
//   instr_count  out  CNT_W   number of cycles in which cpu_ce was high
// BEHAVIOUR
//   - Reset (async, rst=1): state=HALT, cpu_ce=0, halted=1, view=0, instr_count=0.
//     Synchronizers, debounce counters, debounced levels and the scan timer all clear to 0.
//     Asserting rst during RUN or STEP drops cpu_ce at once, without waiting for a clock edge.
//   - run_sw and step_btn each pass through a 2-flop synchronizer. The debounced level
//     takes the synchronized value after DB_CYCLES consecutive equal samples. Any mismatch
//     reloads the counter to 0.
//   - step_req: one-cycle pulse on the 0->1 edge of the debounced step level.
//   - FSM (registered state; cpu_ce and halted decode from state only, glitch-free):
//       HALT: cpu_ce=0, halted=1. run_db=1 -> RUN (run has priority, step_req dropped);
//             else step_req -> STEP.
//       RUN : cpu_ce=1, halted=0. run_db=0 -> HALT.
//       STEP: cpu_ce=1 for exactly one cycle, halted=1. Always -> WAIT.
//       WAIT: cpu_ce=0, halted=1. run_db=1 -> RUN. Debounced step=0 -> HALT. Otherwise stay.
//             A held button therefore gives exactly one step.
//   - instr_count increments on every clock edge where cpu_ce=1. It wraps from 2^CNT_W-1 to 0
//     and holds while cpu_ce=0.
//   - view is registered and follows view_sel with 1-cycle latency, except in auto-scan as
//     described below.
// CONFIGURATION
//   AUTO_SCAN_EN defined: while halted=1 and auto_scan=1, view comes from an internal counter.
//     - The counter starts from the current view value.
//     - It advances by 1 every SCAN_CYCLES cycles and wraps 2^VIEW_W-1 -> 0.
//     - If auto_scan=0 or halted=0, view follows view_sel (1-cycle latency) and the scan
//       timer clears to 0.
//   AUTO_SCAN_EN undefined: no scan timer is built; auto_scan is ignored.
// TESTING (bench: DB_CYCLES=4, SCAN_CYCLES=8)
//   1. Hold rst 3 cycles, all inputs 0 -> cpu_ce=0, halted=1, view=0, instr_count=0.
//   2. step_btn=1 for 100 cycles, then 0 -> exactly one cpu_ce=1 cycle, no later than
//      cycle 8 after press; instr_count=1; FSM returns to HALT after release debounces.
//   3. step_btn=1 for 3 cycles (glitch shorter than debounce) -> cpu_ce never high, instr_count=0.
//   4. run_sw=1 for 40 cycles, then 0 -> cpu_ce continuous once debounced; instr_count equals
//      the number of high cycles; halted=1 and count frozen after release debounces.
//   5. run_sw and step_btn rise together -> RUN entered, no separate STEP pulse. Assert rst
//      mid-RUN -> cpu_ce=0 before the next clk edge; view=0; instr_count=0.
//   6. AUTO_SCAN_EN, halted, auto_scan=1, view=30 -> view 30,31,0,1 at 8-cycle spacing.
//      Without the macro: view_sel=5'd17 -> view=17 one cycle later.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller for the single-cycle datapath.
// Turns the run switch and the step button into a datapath clock-enable.
// The datapath can free-run, halt, or advance one instruction per press.
// It also drives the register-view index and counts executed instructions.
// Build option AUTO_SCAN_EN: while halted with auto_scan=1, the view index
// steps through the registers on its own, one step every SCAN_CYCLES cycles.

// Per-input conditioner: 2-flop synchronizer followed by a level debouncer.
module cpu_run_ctrl_db #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // bring the raw input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // the level flips only after DB_CYCLES back-to-back samples disagree with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module cpu_run_ctrl #(
  parameter int DB_CYCLES   = 250000,
  parameter int SCAN_CYCLES = 50000000,
  parameter int VIEW_W      = 5,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic [VIEW_W-1:0] view_sel,
  input  logic              auto_scan,
  output logic              cpu_ce,
  output logic              halted,
  output logic [VIEW_W-1:0] view,
  output logic [CNT_W-1:0]  instr_count
);
  typedef enum logic [1:0] {HALT, RUN, STEP, WAIT} state_t;

  // Input 1 is the run switch and input 0 is the step button.
  logic [1:0] raw, lvl;
  logic       run_db, step_db, step_prev, step_req;
  state_t     state, state_nx;

  assign raw = {run_sw, step_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      cpu_run_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw[gi]),
        .level (lvl[gi])
      );
    end
  endgenerate

  assign run_db   = lvl[1];
  assign step_db  = lvl[0];
  assign step_req = step_db & ~step_prev;

  // remember the last debounced step level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_prev <= 1'b0;
    else     step_prev <= step_db;
  end

  // state register; an async reset drops cpu_ce immediately through the decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HALT;
    else     state <= state_nx;
  end

  // next state, with outputs decoded purely from the registered state
  always_comb begin
    state_nx = state;
    cpu_ce   = 1'b0;
    halted   = 1'b1;
    case (state)
      HALT: begin
        if (run_db)        state_nx = RUN;
        else if (step_req) state_nx = STEP;
      end
      RUN: begin
        cpu_ce = 1'b1;
        halted = 1'b0;
        if (!run_db) state_nx = HALT;
      end
      STEP: begin
        cpu_ce   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        // a held button parks here, so it gives exactly one step
        if (run_db)        state_nx = RUN;
        else if (!step_db) state_nx = HALT;
      end
      default: state_nx = HALT;
    endcase
  end

  // count every cycle in which the datapath advanced; this wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_count <= '0;
    else if (cpu_ce) instr_count <= instr_count + 1'b1;
  end

`ifdef AUTO_SCAN_EN
  localparam int TW = (SCAN_CYCLES < 2) ? 1 : $clog2(SCAN_CYCLES + 1);
  logic [TW-1:0] scan_tmr;

  // In auto-scan, view is its own counter and starts from the current index.
  // Otherwise view tracks the switches and the timer is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_tmr <= '0;
      view     <= '0;
    end else if (halted && auto_scan) begin
      if (scan_tmr == TW'(SCAN_CYCLES - 1)) begin
        scan_tmr <= '0;
        view     <= view + 1'b1;
      end else begin
        scan_tmr <= scan_tmr + 1'b1;
      end
    end else begin
      scan_tmr <= '0;
      view     <= view_sel;
    end
  end
`else
  logic unused_auto_scan;
  assign unused_auto_scan = auto_scan;

  // register the manual view select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) view <= '0;
    else     view <= view_sel;
  end
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with short debounce/scan constants.
// A reference model predicts the outputs after every clock or reset event
// and queues them; a monitor compares the DUT against the queue each cycle.
module tb_cpu_run_ctrl;
  localparam int DB   = 4;
  localparam int SCAN = 8;
  localparam int VW   = 5;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_sw = 1'b0, step_btn = 1'b0, auto_scan = 1'b0;
  logic [VW-1:0] view_sel = '0;
  logic          cpu_ce, halted;
  logic [VW-1:0] view;
  logic [CW-1:0] instr_count;

  int compared = 0;
  int mismatched = 0;

  cpu_run_ctrl #(.DB_CYCLES(DB), .SCAN_CYCLES(SCAN), .VIEW_W(VW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .view_sel(view_sel),
    .auto_scan(auto_scan), .cpu_ce(cpu_ce), .halted(halted), .view(view),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ce;
    logic          hl;
    logic [VW-1:0] view;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  // ---------------- reference model ----------------
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_WAIT = 3;
  int            m_mode;
  bit            m_run_db, m_step_db, m_step_prev;
  bit            m_r1run, m_r2run, m_r1step, m_r2step;
  bit            seen_run[$], seen_step[$];
  logic [CW-1:0] m_cnt;
  logic [VW-1:0] m_view;
  int            m_tmr;

  // the level becomes v once the last DB samples it saw were all v
  function automatic bit settle(input bit lvl, input bit q[$]);
    if (q.size() < DB) return lvl;
    for (int i = 0; i < DB; i++)
      if (q[q.size() - 1 - i] == lvl) return lvl;
    return !lvl;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_HALT; m_run_db = 0; m_step_db = 0; m_step_prev = 0;
      m_r1run = 0; m_r2run = 0; m_r1step = 0; m_r2step = 0;
      seen_run.delete(); seen_step.delete();
      m_cnt = '0; m_view = '0; m_tmr = 0;
    end else begin
      bit ce_pre, halted_pre, req;
      ce_pre     = (m_mode == M_RUN) || (m_mode == M_STEP);
      halted_pre = (m_mode != M_RUN);
      req        = m_step_db && !m_step_prev;
      case (m_mode)
        M_HALT:  m_mode = m_run_db ? M_RUN : (req ? M_STEP : M_HALT);
        M_RUN:   m_mode = m_run_db ? M_RUN : M_HALT;
        M_STEP:  m_mode = M_WAIT;
        default: m_mode = m_run_db ? M_RUN : (m_step_db ? M_WAIT : M_HALT);
      endcase
      if (ce_pre) m_cnt = m_cnt + 1'b1;
`ifdef AUTO_SCAN_EN
      if (halted_pre && auto_scan) begin
        m_tmr++;
        if (m_tmr == SCAN) begin m_tmr = 0; m_view = m_view + 1'b1; end
      end else begin
        m_tmr = 0; m_view = view_sel;
      end
`else
      m_view = view_sel;
      if (halted_pre) m_tmr = 0;
`endif
      m_step_prev = m_step_db;
      seen_run.push_back(m_r2run);
      seen_step.push_back(m_r2step);
      if (seen_run.size() > DB)  void'(seen_run.pop_front());
      if (seen_step.size() > DB) void'(seen_step.pop_front());
      m_r2run = m_r1run;   m_r1run = run_sw;
      m_r2step = m_r1step; m_r1step = step_btn;
      m_run_db  = settle(m_run_db, seen_run);
      m_step_db = settle(m_step_db, seen_step);
    end
    sb.push_back('{ce: (m_mode == M_RUN) || (m_mode == M_STEP), hl: (m_mode != M_RUN),
                   view: m_view, cnt: m_cnt});
  end

  // ---------------- monitor ----------------
  // several events can land in one cycle (async reset); the latest one is live
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      while (sb.size() > 1) void'(sb.pop_front());
      e = sb.pop_front();
      compared++;
      if ({cpu_ce, halted, view, instr_count} !== e) begin
        mismatched++;
        $display("FAIL cycle_check t=%0t got ce=%b halted=%b view=%0d count=%0d want ce=%b halted=%b view=%0d count=%0d",
                 $time, cpu_ce, halted, view, instr_count, e.ce, e.hl, e.view, e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    run_sw = 0; step_btn = 0; auto_scan = 0; view_sel = '0;
    rst = 1; cyc(3); rst = 0; cyc(1);
  endtask

  initial begin
    int ce_cnt, first;

    // 1. reset state
    cyc(3);
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_halted", halted, 1);
    chk("rst_view", view, 0);
    chk("rst_count", instr_count, 0);
    rst = 0; cyc(1);

    // 2. long press gives one step
    ce_cnt = 0; first = -1;
    step_btn = 1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (cpu_ce) begin ce_cnt++; if (first < 0) first = i; end
    end
    step_btn = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (cpu_ce) ce_cnt++; end
    chk("step_pulses", ce_cnt, 1);
    chk("step_latency_le8", int'(first >= 1 && first <= 8), 1);
    chk("step_count", instr_count, 1);
    chk("step_halted", halted, 1);

    // 3. glitch shorter than debounce
    do_reset();
    ce_cnt = 0;
    step_btn = 1; cyc(3); step_btn = 0;
    for (int i = 0; i < 15; i++) begin cyc(1); if (cpu_ce) ce_cnt++; end
    chk("glitch_pulses", ce_cnt, 0);
    chk("glitch_count", instr_count, 0);

    // 4. free run for 40 cycles
    do_reset();
    ce_cnt = 0;
    run_sw = 1;
    for (int i = 0; i < 40; i++) begin cyc(1); if (cpu_ce) ce_cnt++; end
    run_sw = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (cpu_ce) ce_cnt++; end
    chk("run_ce_cycles", ce_cnt, 40);
    chk("run_count", instr_count, 40);
    chk("run_halted_after", halted, 1);
    cyc(5);
    chk("run_count_frozen", instr_count, 40);

    // 5. run and step together, then async reset mid-run
    do_reset();
    run_sw = 1; step_btn = 1;
    cyc(10);
    chk("both_running", halted, 0);
    chk("both_count", instr_count, 3);
    rst = 1; #1;
    chk("async_rst_ce", cpu_ce, 0);
    chk("async_rst_count", instr_count, 0);
    chk("async_rst_view", view, 0);
    cyc(2);
    run_sw = 0; step_btn = 0; rst = 0; cyc(1);

    // 6. view path
`ifdef AUTO_SCAN_EN
    view_sel = 5'd30; cyc(2);
    chk("scan_start", view, 30);
    auto_scan = 1; view_sel = 5'd3;
    cyc(8);  chk("scan_1", view, 31);
    cyc(8);  chk("scan_2", view, 0);
    cyc(8);  chk("scan_3", view, 1);
    auto_scan = 0; cyc(1);
    chk("scan_off", view, 3);
`else
    view_sel = 5'd17; cyc(1);
    chk("view_latency", view, 17);
`endif

    // randomized traffic against the model
    for (int blk = 0; blk < 150; blk++) begin
      run_sw    = ($urandom_range(0, 3) == 0);
      step_btn  = 1'($urandom_range(0, 1));
      view_sel  = VW'($urandom);
      auto_scan = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin rst = 1; cyc(2); rst = 0; end
      cyc($urandom_range(1, 14));
    end
    run_sw = 0; step_btn = 0; auto_scan = 0;
    cyc(12);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
